// File: rtl/mmio_pkg.sv
// Shared types and widths for the MMIO block mover.
// Address bit DMEM_SPACE_BIT selects non-DMEM space.
package mmio_pkg;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int DMEM_SPACE_BIT = 12;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RD,
      WR,
      DONE
   } state_t;
endpackage

// File: rtl/mmio_rd_delay.sv
// Read-strobe delay line: capture fires on the RD_LAT-th RD cycle.
// The strobe is raised in the cycle before RD is entered.
module mmio_rd_delay #(
   parameter int RD_LAT = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic strobe,
   output logic capture
);
   logic [RD_LAT-1:0] sr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr <= '0;
      end else begin
         sr[0] <= strobe;
         for (int i = 1; i < RD_LAT; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign capture = sr[RD_LAT-1];
endmodule

// File: rtl/mmio_block_mover.sv
// MMIO bus initiator that copies or fills blocks of words.
// Grant is only sampled in REQ and on leaving WR.
module mmio_block_mover
   import mmio_pkg::*;
#(
   parameter int LEN_W  = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_fill,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              bus_req,
   input  logic              bus_grant,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done
);
   state_t              state;
   state_t              state_nx;
   logic [ADDR_W-1:0]   src_q;
   logic [ADDR_W-1:0]   dst_q;
   logic [LEN_W-1:0]    cnt_q;
   logic                fill_q;
   logic [DATA_W-1:0]   data_q;
   logic [ADDR_W-1:0]   addr_hold;
   logic [DATA_W-1:0]   wdata_hold;
   logic                strobe;
   logic                capture;

   mmio_rd_delay #(.RD_LAT(RD_LAT)) u_rd_delay (
      .clock   (clock),
      .reset   (reset),
      .strobe  (strobe),
      .capture (capture)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nx = (cmd_len == '0) ? DONE : REQ;
            end
         end
         REQ: begin
            if (bus_grant) begin
               state_nx = fill_q ? WR : RD;
            end
         end
         RD: begin
            if (capture) begin
               state_nx = WR;
            end
         end
         WR: begin
            if (cnt_q == LEN_W'(1)) begin
               state_nx = DONE;
            end else if (bus_grant) begin
               state_nx = fill_q ? WR : RD;
            end else begin
               state_nx = REQ;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      strobe = (state_nx == RD) && (state != RD);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         cnt_q      <= '0;
         fill_q     <= 1'b0;
         data_q     <= '0;
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && cmd_valid) begin
            src_q  <= cmd_src;
            dst_q  <= cmd_dst;
            cnt_q  <= cmd_len;
            fill_q <= cmd_fill;
            data_q <= cmd_data;
         end
         if (state == RD) begin
            addr_hold <= src_q;
            if (capture) begin
               data_q <= mem_rdata;
            end
         end
         // Address wraps modulo 2^ADDR_W by plain overflow.
         if (state == WR) begin
            addr_hold  <= dst_q;
            wdata_hold <= data_q;
            src_q      <= src_q + ADDR_W'(1);
            dst_q      <= dst_q + ADDR_W'(1);
            cnt_q      <= cnt_q - LEN_W'(1);
         end
      end
   end

   always_comb begin
      mem_address = addr_hold;
      mem_wdata   = wdata_hold;
      if (state == RD) begin
         mem_address = src_q;
      end else if (state == WR) begin
         mem_address = dst_q;
         mem_wdata   = data_q;
      end
   end

   assign mem_wren  = (state == WR);
   assign bus_req   = (state == REQ) || (state == RD) || (state == WR);
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
endmodule

// File: tb/tb_mmio_block_mover.sv
// Self-checking bench: directed and random copy/fill commands
// checked against an array-based reference of the block mover.
module tb_mmio_block_mover;
   typedef struct {
      logic [12:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_fill;
   logic [12:0] cmd_src;
   logic [12:0] cmd_dst;
   logic [11:0] cmd_len;
   logic [31:0] cmd_data;
   logic        bus_req;
   logic        bus_grant;
   logic [12:0] mem_address;
   logic [31:0] mem_wdata;
   logic        mem_wren;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;

   logic [31:0] dmem [4096];
   logic [31:0] refm [4096];
   wr_t         wlog [$];
   int          total = 0;
   int          bad = 0;

   always #5 clock = ~clock;

   mmio_block_mover dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_fill    (cmd_fill),
      .cmd_src     (cmd_src),
      .cmd_dst     (cmd_dst),
      .cmd_len     (cmd_len),
      .cmd_data    (cmd_data),
      .bus_req     (bus_req),
      .bus_grant   (bus_grant),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_wren    (mem_wren),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .done        (done)
   );

   // MMIO device: DMEM below 0x1000, a fixed pattern above it.
   assign mem_rdata = mem_address[12] ?
                      (32'hBAD0_0000 | {19'd0, mem_address}) :
                      dmem[mem_address[11:0]];

   always @(posedge clock) begin
      if (!reset && mem_wren) begin
         wlog.push_back('{mem_address, mem_wdata});
         if (!mem_address[12]) dmem[mem_address[11:0]] = mem_wdata;
      end
   end

   function automatic logic [31:0] ref_rd(input logic [12:0] a);
      return a[12] ? (32'hBAD0_0000 | {19'd0, a}) : refm[a[11:0]];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_bus_req"}, bus_req, 0);
      chk({tag, "_wren"}, mem_wren, 0);
      chk({tag, "_addr"}, mem_address, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
   endtask

   task automatic run_cmd(input string tag, input bit fill,
                          input logic [12:0] src, input logic [12:0] dst,
                          input logic [11:0] len, input logic [31:0] data,
                          input int g_delay, input int drop_at,
                          input int drop_len, input bit rnd);
      wr_t         expq [$];
      int          wc [$];
      int          log0, cyc, done_cyc, done_cnt, busy_cnt;
      int          gviol, rviol, drop_until, span;
      bit          breq, exact;
      logic [12:0] ad, as;
      logic [31:0] v;
      for (int i = 0; i < int'(len); i++) begin
         ad = dst + 13'(i);
         as = src + 13'(i);
         v  = fill ? data : ref_rd(as);
         expq.push_back('{ad, v});
         if (!ad[12]) refm[ad[11:0]] = v;
      end
      exact = (g_delay == 0) && (drop_at == 0) && !rnd && (len != 0);
      log0 = wlog.size();
      done_cyc = 0; done_cnt = 0; busy_cnt = 0;
      gviol = 0; rviol = 0; drop_until = 0; breq = 0;
      @(negedge clock);
      bus_grant = rnd ? 1'($urandom_range(0, 1)) : (g_delay == 0);
      cmd_fill = fill; cmd_src = src; cmd_dst = dst;
      cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
      chk({tag, "_ready"}, cmd_ready, 1);
      @(negedge clock);
      cmd_valid = 1'b0;
      for (cyc = 1; cyc < 400 + 40 * int'(len); cyc++) begin
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (busy) busy_cnt++;
         if (busy && cmd_ready) rviol++;
         if (mem_wren && !bus_grant) gviol++;
         if (bus_req) breq = 1;
         if (mem_wren) wc.push_back(cyc);
         if (done_cnt > 0 && cyc > done_cyc) break;
         if (rnd) begin
            if (bus_grant) begin
               if (mem_wren && $urandom_range(0, 3) == 0) bus_grant = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               bus_grant = 1'b1;
            end
         end else begin
            if (drop_at > 0 && mem_wren && (wlog.size() - log0) == drop_at - 1)
               drop_until = cyc + drop_len;
            bus_grant = (cyc >= g_delay) && (cyc >= drop_until);
         end
         @(negedge clock);
      end
      chk({tag, "_done_seen"}, done_cnt > 0, 1);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_nwrites"}, wlog.size() - log0, expq.size());
      if (wlog.size() - log0 == expq.size()) begin
         foreach (expq[i])
            chk({tag, "_write"}, {wlog[log0+i].a, wlog[log0+i].d},
                {expq[i].a, expq[i].d});
      end
      chk({tag, "_busy_cycles"}, busy_cnt, done_cyc);
      chk({tag, "_wren_no_grant"}, gviol, 0);
      chk({tag, "_ready_busy"}, rviol, 0);
      if (len == 0) begin
         chk({tag, "_no_bus_req"}, breq, 0);
         chk({tag, "_done_soon"}, done_cyc >= 1 && done_cyc <= 2, 1);
      end
      if (exact) begin
         chk({tag, "_done_cycle"}, done_cyc,
             fill ? int'(len) + 2 : 2 * int'(len) + 2);
         if (wc.size() == int'(len)) begin
            span = wc[wc.size()-1] - wc[0];
            chk({tag, "_write_span"}, span,
                fill ? int'(len) - 1 : 2 * (int'(len) - 1));
            chk({tag, "_done_after_wr"}, done_cyc - wc[wc.size()-1], 1);
         end
      end
   endtask

   initial begin : main
      int          log0, dn, mm;
      logic [31:0] v;
      logic [12:0] s, d;
      reset = 1'b1; cmd_valid = 1'b0; cmd_fill = 1'b0;
      cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_data = '0;
      bus_grant = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         v = $urandom; dmem[i] = v; refm[i] = v;
      end
      repeat (2) @(negedge clock);
      chk_idle_outputs("reset");
      reset = 1'b0;

      run_cmd("fill4", 1, 13'h0, 13'h100, 12'd4, 32'hDEAD_BEEF, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         chk("fill4_mem", dmem[12'h100 + 12'(i)], 32'hDEAD_BEEF);

      for (int i = 0; i < 3; i++) begin
         dmem[12'h010 + 12'(i)] = 32'(i + 1);
         refm[12'h010 + 12'(i)] = 32'(i + 1);
      end
      run_cmd("copy3", 0, 13'h010, 13'h200, 12'd3, 32'h0, 0, 0, 0, 0);
      chk("copy3_mem2", dmem[12'h202], 32'd3);

      run_cmd("len0", 1, 13'h0, 13'h080, 12'd0, 32'h1111_1111, 0, 0, 0, 0);

      run_cmd("gdrop", 1, 13'h0, 13'h300, 12'd4, 32'hA5A5_5A5A, 5, 2, 4, 0);

      run_cmd("wrap", 1, 13'h0, 13'h1FFE, 12'd3, 32'h1234_5678, 0, 0, 0, 0);
      chk("wrap_mem0", dmem[0], 32'h1234_5678);

      log0 = wlog.size();
      @(negedge clock);
      bus_grant = 1'b1;
      cmd_fill = 1'b0; cmd_src = 13'h040; cmd_dst = 13'h500;
      cmd_len = 12'd5; cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      for (int i = 0; i < 20 && wlog.size() == log0; i++) @(negedge clock);
      chk("rst_first_write", wlog.size() - log0, 1);
      reset = 1'b1;
      #1;
      chk_idle_outputs("rst_mid");
      refm[12'h500] = refm[12'h040];
      @(negedge clock);
      reset = 1'b0;
      dn = 0;
      repeat (12) begin
         @(negedge clock);
         if (done) dn++;
      end
      chk("rst_no_done", dn, 0);
      chk("rst_nwrites", wlog.size() - log0, 1);
      if (wlog.size() > log0)
         chk("rst_write", {wlog[log0].a, wlog[log0].d},
             {13'h500, refm[12'h040]});
      run_cmd("after_rst", 0, 13'h040, 13'h600, 12'd2, 32'h0, 0, 0, 0, 0);

      for (int k = 0; k < 20; k++) begin
         s = 13'($urandom_range(0, 8191));
         d = ($urandom_range(0, 2) == 0) ? s + 13'($urandom_range(0, 4)) :
             13'($urandom_range(0, 8191));
         run_cmd($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), s, d,
                 12'($urandom_range(0, 10)), $urandom, 0, 0, 0, 1);
      end

      mm = 0;
      for (int i = 0; i < 4096; i++)
         if (dmem[i] !== refm[i]) mm++;
      chk("mem_final", mm, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
